// File: rtl/sram_1p_responder_if.sv
// sram_1p_responder_if: functional and BIST port bundle of the single-port SRAM macro
interface sram_1p_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              a_men;
    logic              a_wen;
    logic              a_ren;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] a_bm;
    logic              a_dly;
    logic              a_bist_en;
    logic              a_bist_men;
    logic              a_bist_wen;
    logic              a_bist_ren;
    logic [ADDR_W-1:0] a_bist_addr;
    logic [DATA_W-1:0] a_bist_din;
    logic [DATA_W-1:0] a_bist_bm;
    logic [DATA_W-1:0] a_dout;
    logic              rd_valid;

    modport master (
        output a_men, a_wen, a_ren, a_addr, a_din, a_bm, a_dly,
        output a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr, a_bist_din, a_bist_bm,
        input  a_dout, rd_valid
    );

    modport slave (
        input  a_men, a_wen, a_ren, a_addr, a_din, a_bm, a_dly,
        input  a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr, a_bist_din, a_bist_bm,
        output a_dout, rd_valid
    );
endinterface

// File: rtl/sram_1p_responder.sv
// sram_1p_responder: flop-based single-port SRAM model with BIST mux and protocol checker
module sram_1p_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_1p_responder_if.slave  p,
    input  logic                err_clr,
    output logic                err_conflict,
    output logic                err_range,
    output logic [7:0]          err_cnt
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              conf_q, conf_d;
    logic              range_q, range_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              men, wen, ren, in_range, conflict, range_e, we;
    logic [ADDR_W-1:0] addr;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] din, bm, old;
    logic              unused_dly;

    assign unused_dly = p.a_dly;

    always_comb begin
        men      = p.a_bist_en ? p.a_bist_men  : p.a_men;
        wen      = p.a_bist_en ? p.a_bist_wen  : p.a_wen;
        ren      = p.a_bist_en ? p.a_bist_ren  : p.a_ren;
        addr     = p.a_bist_en ? p.a_bist_addr : p.a_addr;
        din      = p.a_bist_en ? p.a_bist_din  : p.a_din;
        bm       = p.a_bist_en ? p.a_bist_bm   : p.a_bm;
        idx      = addr[IW-1:0];
        in_range = 32'(addr) < 32'(DEPTH);
        old      = mem_q[idx];
        conflict = men & wen & ren;
        range_e  = men & (wen | ren) & ~in_range;
        we       = men & wen & in_range;
        // out-of-range reads still complete, returning zero
        dout_d     = (men & ren) ? (in_range ? old : '0) : dout_q;
        rd_valid_d = men & ren;
        conf_d     = conflict | (conf_q & ~err_clr);
        range_d    = range_e | (range_q & ~err_clr);
        cnt_d      = err_clr ? {7'd0, conflict | range_e}
                   : ((conflict | range_e) && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    // array has no reset; writes are blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (rst_n && we) mem_q[idx] <= (old & ~bm) | (din & bm);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            conf_q     <= 1'b0;
            range_q    <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            conf_q     <= conf_d;
            range_q    <= range_d;
            cnt_q      <= cnt_d;
        end
    end

    assign p.a_dout     = dout_q;
    assign p.rd_valid   = rd_valid_q;
    assign err_conflict = conf_q;
    assign err_range    = range_q;
    assign err_cnt      = cnt_q;
endmodule

// File: doc/sram_1p_responder.md
Name: sram_1p_responder

Overview:
Synthesizable responder for the single-port SRAM macro interface (MEN/WEN/REN/ADDR/DIN/BM/DOUT plus BIST port), built from flops. It replaces the hard macro in simulation and FPGA builds, and acts as the golden port model when verifying the tile wrapper that drives the macro. It adds a protocol checker that flags and counts illegal port usage.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data and byte-mask width (bit-granular mask)
DEPTH, 256, implemented words; must be <= 2**ADDR_W

Ports:
clk  in  1  clock; all sampling on rising edge
rst_n  in  1  asynchronous active-low reset
a_men  in  1  functional port memory enable
a_wen  in  1  functional write enable
a_ren  in  1  functional read enable
a_addr  in  ADDR_W  functional address
a_din  in  DATA_W  functional write data
a_bm  in  DATA_W  functional bit mask; 1 = bit written
a_dly  in  1  delay trim; accepted and ignored; no effect on latency
a_bist_en  in  1  1 = BIST port owns the array this cycle
a_bist_men, a_bist_wen, a_bist_ren  in  1 each  BIST equivalents
a_bist_addr  in  ADDR_W  BIST address
a_bist_din  in  DATA_W  BIST write data
a_bist_bm  in  DATA_W  BIST bit mask
err_clr  in  1  synchronous clear of error flags and counter
a_dout  out  DATA_W  read data
rd_valid  out  1  1-cycle pulse: a_dout updated this cycle
err_conflict  out  1  sticky: REN and WEN both high with MEN
err_range  out  1  sticky: access with address >= DEPTH
err_cnt  out  8  saturating count of illegal accesses

Behaviour:
- Effective port per cycle: a_bist_en ? BIST signals : functional signals. The mux is combinational before the sample edge. The same rules apply to both sources.
- Reset (rst_n low, async): a_dout=0, rd_valid=0, err_conflict=0, err_range=0, err_cnt=0. The array is not reset and its contents are preserved. No write is performed on any edge while rst_n is low.
- men=0: no access; a_dout holds; rd_valid=0.
- Write (men=1, wen=1, ren=0, addr<DEPTH): mem[addr] <= (mem[addr] & ~bm) | (din & bm). a_dout holds; rd_valid=0.
- Read (men=1, ren=1, wen=0, addr<DEPTH): on the sample edge, a_dout <= mem[addr], so the data is visible in the cycle after request. rd_valid=1 for exactly that cycle. a_dout holds until the next read, even with men=0.
- Back-to-back reads: one result per cycle. Read of an address written in the previous cycle returns the new data.
- Conflict (men=1, ren=1, wen=1):
  - the masked write is performed;
  - a_dout <= old mem[addr] (read-before-write); rd_valid=1;
  - err_conflict <= 1; err_cnt increments.
- Range (men=1, addr>=DEPTH, ren or wen): no array change. A read returns a_dout=0 with rd_valid=1. err_range <= 1; err_cnt increments.
- Conflict and range in the same cycle: both flags set; err_cnt increments by 1 only.
- men=1 with ren=0 and wen=0: legal no-op.
- err_cnt saturates at 255 and does not wrap.
- err_clr=1: flags and count cleared at the edge. If an error occurs in the same cycle, the flag for that error =1 and err_cnt=1 (new error wins).
- Uninitialised words read as unknown in simulation. The bench must write before reading.

Test Plan:
- Reset, write 0xA5 to addr 0x10 with bm=0xFF, read 0x10 -> a_dout=0xA5 and rd_valid=1 exactly one cycle after the read sample; a_dout stays 0xA5 for the following 5 idle cycles with rd_valid=0.
- Masked write 0x0F with bm=0x0F over 0xA5 at 0x10, then read -> 0xAF. Then write 0xFF with bm=0x00, then read -> 0xAF unchanged.
- Conflict: mem[0x20]=0x11; issue ren=wen=1, din=0x22, bm=0xFF at 0x20 -> a_dout=0x11, err_conflict=1, err_cnt=1. A subsequent read of 0x20 -> 0x22.
- BIST takeover: a_bist_en=1, BIST writes 0x5A to 0x03 while the functional port drives a write of 0x99 to 0x03 -> read of 0x03 returns 0x5A. Then drop a_bist_en and perform a functional read of 0x03 -> 0x5A.
- DEPTH=64 build:
  - read at 0x40 -> a_dout=0, rd_valid=1, err_range=1;
  - write at 0x80 leaves mem[0x00] unchanged;
  - 300 illegal accesses -> err_cnt=255;
  - err_clr together with a conflict -> err_cnt=1, err_conflict=1, err_range=0.
- Async reset mid-stream:
  - write 0x77 to 0x05, issue a read of 0x05, assert rst_n low between edges;
  - a_dout and all flags become 0 immediately;
  - a write presented during reset does not land;
  - after release, a read of 0x05 -> 0x77.
